// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, two combinational read ports and
// two synchronous write ports. Lane 1 wins on a same-address write. After
// reset a clear engine zeroes one entry per cycle, so the storage needs no
// reset net.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   we0/waddr0/wdata0      write lane 0
//   we1/waddr1/wdata1      write lane 1 (priority over lane 0)
//   raddr0/rdata0          read port 0 (combinational)
//   raddr1/rdata1          read port 1 (combinational)
//   busy                   high while the clear engine runs
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;
    logic              clr_en;
    logic              wr0_en;
    logic              wr1_en;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state, clear-engine and write-enable decode.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_en    = 1'b0;
        wr0_en    = 1'b0;
        wr1_en    = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    // Counter parks at the last entry; never wraps back to 0.
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                wr0_en = we0 && !(ZERO_REG && (waddr0 == '0));
                wr1_en = we1 && !(ZERO_REG && (waddr1 == '0));
            end
            default: state_d = ST_CLEAR;
        endcase
        // No entry is touched on an edge that samples reset.
        if (rst) begin
            clr_en = 1'b0;
            wr0_en = 1'b0;
            wr1_en = 1'b0;
        end
        busy_d = (state_d == ST_CLEAR);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Storage: no reset, so it maps onto distributed RAM. Lane 1 is written
    // last so it overrides lane 0 on an address collision.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_cnt_q] <= '0;
        end
        if (wr0_en) begin
            mem[waddr0] <= wdata0;
        end
        if (wr1_en) begin
            mem[waddr1] <= wdata1;
        end
    end

    // Read port 0: later assignments take precedence (busy highest).
    always_comb begin
        rdata0 = mem[raddr0];
        if (BYPASS && we0 && (waddr0 == raddr0)) rdata0 = wdata0;
        if (BYPASS && we1 && (waddr1 == raddr0)) rdata0 = wdata1;
        if (ZERO_REG && (raddr0 == '0))          rdata0 = '0;
        if (busy_q)                              rdata0 = '0;
    end

    // Read port 1: same resolution as port 0.
    always_comb begin
        rdata1 = mem[raddr1];
        if (BYPASS && we0 && (waddr0 == raddr1)) rdata1 = wdata0;
        if (BYPASS && we1 && (waddr1 == raddr1)) rdata1 = wdata1;
        if (ZERO_REG && (raddr1 == '0))          rdata1 = '0;
        if (busy_q)                              rdata1 = '0;
    end

    assign busy = busy_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next-generation replacement for the single-write, two-read CPU register file. It provides two combinational read ports and two synchronous write ports, with configurable width, depth, hard-wired zero register, and same-cycle write-to-read bypass. After reset, a sequential clear engine zeroes every entry one per cycle, so the storage maps onto distributed RAM without a global reset net. It sits between the decode stage (read ports) and the writeback stage, which drives two retire lanes (write ports).

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth DEPTH = 2^ADDR_W entries.
- ZERO_REG, 1: 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary.
- BYPASS, 1: 1 = a read returns same-cycle write data on an address match; 0 = a read returns the stored (pre-edge) value.
- clk  in  1  single clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we0  in  1  write enable, lane 0.
- waddr0  in  ADDR_W  write address, lane 0.
- wdata0  in  DATA_W  write data, lane 0.
- we1  in  1  write enable, lane 1. Lane 1 has priority over lane 0.
- waddr1  in  ADDR_W  write address, lane 1.
- wdata1  in  DATA_W  write data, lane 1.
- raddr0  in  ADDR_W  read address, port 0.
- rdata0  out  DATA_W  read data, port 0 (combinational).
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1 (combinational).
- busy  out  1  high while the clear engine runs; writes are ignored and reads return 0.

## Operation
- FSM states:
  - CLEAR: clear engine active.
  - READY: normal operation.
- Reset: `rst` high at an edge puts the FSM in CLEAR with clear counter `clr_cnt` = 0. This holds every cycle `rst` stays high; no entry is written while `rst` is high.
- CLEAR with `rst` low, at each edge:
  - mem[`clr_cnt`] ← 0.
  - `clr_cnt` increments.
  - When `clr_cnt` == DEPTH-1, the FSM moves to READY.
- CLEAR is never re-entered except by `rst`.
- READY writes, at each edge:
  - If `we0` is set, mem[`waddr0`] ← `wdata0`.
  - If `we1` is set, mem[`waddr1`] ← `wdata1`.
  - Both enabled to the same address: `wdata1` is stored and `wdata0` is dropped.
  - With ZERO_REG=1, any write to address 0 is discarded.
- Reads (combinational), per port, evaluated in this order:
  1. `busy` = 1: output 0.
  2. ZERO_REG=1 and address 0: output 0.
  3. BYPASS=1, `we1` set and `waddr1` matches: output `wdata1`.
  4. BYPASS=1, `we0` set and `waddr0` matches: output `wdata0`.
  5. Otherwise: output the stored mem value.
- Both read ports may address the same entry; each resolves independently.
- Width rules: addresses are used unsigned and unmodified. No truncation or extension of data.

## Timing
- Output reset values:
  - `busy` = 1.
  - `rdata0` = `rdata1` = 0 for the whole time `busy` is high.
- Clear latency: `busy` falls exactly DEPTH rising edges after the first edge sampling `rst` low. With ADDR_W=5 this is 32 edges.
- The first edge with `busy` = 0 accepts writes.
- Write latency: data is visible in the array after one edge.
  - BYPASS=1: visible in the same cycle through the bypass path.
  - BYPASS=0: first visible the cycle after the edge.
- Reset mid-operation:
  - `rst` asserted in READY: `busy` = 1 on the next edge, and the clear restarts from entry 0. Prior contents are destroyed by the time `busy` falls.
  - `rst` asserted during CLEAR: `clr_cnt` returns to 0 and the full DEPTH-cycle clear repeats.
- Counter wrap: `clr_cnt` is ADDR_W bits and stops at DEPTH-1; it never wraps to overwrite entry 0 in READY.
- Writes presented while `busy` = 1 are lost, not queued.

## Test plan
All scenarios use defaults DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1 unless stated.
- Reset/clear:
  - Stimulus: hold `rst` 3 cycles, release, count edges.
  - Required: `busy` = 1 for exactly 32 edges, then 0; `rdata0`/`rdata1` = 0 throughout.
  - Then read addresses 1..31: all return 0x00000000.
- Dual write / conflict:
  - Stimulus: `we0`=1, `waddr0`=5, `wdata0`=0xDEADBEEF; `we1`=1, `waddr1`=5, `wdata1`=0x12345678 for one edge; then `raddr0`=5.
  - Required: `rdata0` = 0x12345678.
  - Stimulus: same edge pattern with `waddr1`=6.
  - Required: entry 5 = 0xDEADBEEF and entry 6 = 0x12345678.
- Zero register:
  - Stimulus: `we1`=1, `waddr1`=0, `wdata1`=0xFFFFFFFF; `raddr0`=0.
  - Required: `rdata0` = 0 in the same cycle and after the edge.
  - Rebuild with ZERO_REG=0: same stimulus gives 0xFFFFFFFF after the edge.
- Bypass:
  - Stimulus: entry 4 holds 0x11111111; `we0`=1, `waddr0`=4, `wdata0`=0x5555AAAA; `raddr0`=`raddr1`=4 before the edge.
  - Required: both ports read 0x5555AAAA before the edge.
  - With BYPASS=0: both read 0x11111111 before the edge and 0x5555AAAA after it.
- Write suppressed:
  - Stimulus: `we0`=0, `waddr0`=3, `wdata0`=0xA5A5A5A5 for one edge.
  - Required: entry 3 still reads 0.
  - Stimulus: writes issued while `busy`=1.
  - Required: lost; the entry reads 0 after the clear.
- Reset mid-run:
  - Stimulus: write 0xCAFEF00D to entry 31; assert `rst` for 1 cycle.
  - Required: `busy` high for 32 edges after release; entry 31 then reads 0.
  - Stimulus: repeat with a `rst` pulse at clear cycle 10.
  - Required: `busy` high for 32 edges after that second release.
